// File: rtl/conv_mem_if.sv
// conv_mem_if: loader, convolution-master and result-stream signals of conv_mem (mem_err under CONV_MEM_WRCHK_EN)
interface conv_mem_if;
    logic              start;
    logic              ld_valid;
    logic signed [4:0] ld_data;
    logic              ld_ready;
    logic              conv_reset;
    logic              busy;
    logic              cwr;
    logic [3:0]        caddr_wr;
    logic [4:0]        cdata_wr;
    logic              crd;
    logic [3:0]        caddr_rd;
    logic [4:0]        cdata_rd;
    logic [2:0]        csel;
    logic              out_valid;
    logic [2:0]        out_addr;
    logic [4:0]        out_data;
    logic              out_ready;
    logic              done;
`ifdef CONV_MEM_WRCHK_EN
    logic              mem_err;
`endif

    modport slave (
        input  start, ld_valid, ld_data, busy, cwr, caddr_wr, cdata_wr,
               crd, caddr_rd, csel, out_ready,
`ifdef CONV_MEM_WRCHK_EN
        output mem_err,
`endif
        output ld_ready, conv_reset, cdata_rd, out_valid, out_addr, out_data, done
    );

    modport master (
        output start, ld_valid, ld_data, busy, cwr, caddr_wr, cdata_wr,
               crd, caddr_rd, csel, out_ready,
`ifdef CONV_MEM_WRCHK_EN
        input  mem_err,
`endif
        input  ld_ready, conv_reset, cdata_rd, out_valid, out_addr, out_data, done
    );
endinterface

// File: rtl/conv_mem.sv
// conv_mem: six 16x5 banks shared between loader, convolution master and result dump (option CONV_MEM_WRCHK_EN)
module conv_mem (
    input logic       clk,
    input logic       reset,
    conv_mem_if.slave bus
);
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_DUMP, S_DONE} state_t;

    state_t     r_state;
    state_t     w_next;
    logic [3:0] r_ld_cnt;
    logic [2:0] r_dp_cnt;
    logic       r_seen_busy;
    logic [4:0] r_mem [0:5][0:15];
    logic       w_ld_beat;
    logic       w_dp_beat;
    logic       w_cwr_ok;

    assign w_ld_beat      = (r_state == S_LOAD) && bus.ld_valid;
    assign w_dp_beat      = (r_state == S_DUMP) && bus.out_ready;
    assign w_cwr_ok       = (r_state == S_RUN) && bus.cwr && (bus.csel <= 3'd5);
    assign bus.ld_ready   = (r_state == S_LOAD);
    assign bus.conv_reset = (r_state != S_RUN) && (r_state != S_DUMP);
    assign bus.done       = (r_state == S_DONE);
    assign bus.out_valid  = (r_state == S_DUMP);
    assign bus.out_addr   = (r_state == S_DUMP) ? r_dp_cnt : 3'd0;
    assign bus.out_data   = (r_state == S_DUMP) ? r_mem[5][{1'b0, r_dp_cnt}] : 5'd0;
    assign bus.cdata_rd   = (bus.crd && bus.csel <= 3'd5) ? r_mem[bus.csel][bus.caddr_rd] : 5'd0;

    // Next-state logic: start only matters in IDLE/DONE, other states leave on their final beat
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_DONE: w_next = bus.start ? S_LOAD : r_state;
            S_LOAD:         w_next = (w_ld_beat && r_ld_cnt == 4'd15) ? S_RUN : r_state;
            S_RUN:          w_next = (!bus.busy && r_seen_busy) ? S_DUMP : r_state;
            S_DUMP:         w_next = (w_dp_beat && r_dp_cnt == 3'd7) ? S_DONE : r_state;
            default:        w_next = S_IDLE;
        endcase
    end

    // State, beat counters and the busy-seen flag; counters idle at 0 outside their state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_ld_cnt    <= 4'd0;
            r_dp_cnt    <= 3'd0;
            r_seen_busy <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_ld_cnt    <= w_ld_beat ? r_ld_cnt + 4'd1 : (r_state == S_LOAD) ? r_ld_cnt : 4'd0;
            r_dp_cnt    <= w_dp_beat ? r_dp_cnt + 3'd1 : (r_state == S_DUMP) ? r_dp_cnt : 3'd0;
            r_seen_busy <= (r_state == S_RUN) && (r_seen_busy || bus.busy);
        end
    end

    // Bank storage is never reset so results survive across frames; loader and master never write together
    always_ff @(posedge clk) begin
        if (w_ld_beat)
            r_mem[0][r_ld_cnt] <= bus.ld_data;
        if (w_cwr_ok)
            r_mem[bus.csel][bus.caddr_wr] <= bus.cdata_wr;
    end

`ifdef CONV_MEM_WRCHK_EN
    logic r_mem_err;
    logic w_err;

    assign w_err = (bus.cwr && (bus.csel == 3'd0 || bus.csel > 3'd5))
                 || (bus.cwr && bus.crd)
                 || ((bus.cwr || bus.crd) && r_state != S_RUN);
    assign bus.mem_err = r_mem_err;

    // Sticky access-violation flag, cleared by reset or any start pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_mem_err <= 1'b0;
        else if (bus.start)
            r_mem_err <= 1'b0;
        else if (w_err)
            r_mem_err <= 1'b1;
    end
`endif
endmodule

// File: doc/conv_mem.md
CONV_MEM -- requirements
Module: conv_mem

Interface
REQ-001 SHALL provide one clock and one reset: clk  input  1  rising-edge clock; reset  input  1  asynchronous, active-high reset.
REQ-002 SHALL provide: start  input  1  pulse; begins a new frame from IDLE or DONE.
REQ-003 SHALL provide: ld_valid  input  1; ld_data  input  5 (signed image pixel); ld_ready  output  1.
REQ-004 SHALL provide: conv_reset  output  1  holds the convolution master in reset.
REQ-005 SHALL provide: busy  input  1  master busy.
REQ-006 SHALL provide master-side ports: cwr  input  1; caddr_wr  input  4; cdata_wr  input  5; crd  input  1; caddr_rd  input  4; cdata_rd  output  5; csel  input  3.
REQ-007 SHALL provide result-stream ports: out_valid  output  1; out_addr  output  3; out_data  output  5; out_ready  input  1.
REQ-008 SHALL provide: done  output  1  level; high in DONE.

Function
REQ-009 SHALL hold six banks of 16x5-bit words, selected by csel: 000 image, 001 L0 kernel0, 010 L0 kernel1, 011 L1 bank0, 100 L1 bank1, 101 flattened result.
REQ-010 SHALL drive cdata_rd combinationally as bank[csel][caddr_rd] when crd=1; 0 when crd=0 or csel is 110/111; zero-cycle latency from the registered address.
REQ-011 SHALL write cdata_wr to bank[csel][caddr_wr] at the posedge where cwr=1, state=RUN and csel<=101; the write is ignored otherwise.
REQ-012 SHALL return old data on a same-cycle read and write to the same word; the new value is visible on the following cycle.
REQ-013 SHALL implement FSM states IDLE, LOAD, RUN, DUMP, DONE.
REQ-014 IDLE->LOAD on start; DONE->LOAD on start; start is ignored in LOAD, RUN and DUMP.
REQ-015 LOAD SHALL assert ld_ready; each ld_valid&ld_ready beat writes image[ld_cnt] with ld_cnt counting 0..15; after the beat at ld_cnt=15 the FSM goes to RUN.
REQ-016 conv_reset SHALL be 1 in IDLE, LOAD and DONE, and 0 in RUN and DUMP.
REQ-017 RUN SHALL set a seen_busy flag on busy=1; RUN->DUMP on the first cycle where busy=0 and seen_busy=1; seen_busy is cleared on entering RUN.
REQ-018 DUMP SHALL present out_valid=1, out_addr=dp_cnt and out_data=flat[dp_cnt] for dp_cnt 0..7; dp_cnt advances only on out_valid&out_ready.
REQ-019 DUMP: out_addr and out_data SHALL remain stable while out_ready=0; after the accepted beat at dp_cnt=7 the FSM goes to DONE.
REQ-020 Bank contents SHALL persist across frames; only the image bank is overwritten in LOAD.
REQ-021 ld_ready and out_valid SHALL be 0 outside LOAD and DUMP respectively.

Reset
REQ-022 On reset: state=IDLE, ld_cnt=0, dp_cnt=0, seen_busy=0, ld_ready=0, out_valid=0, out_addr=0, out_data=0, done=0, conv_reset=1.
REQ-023 Bank contents SHALL NOT be reset; reset asserted mid-LOAD, RUN or DUMP aborts the frame and returns to IDLE.

Configuration
REQ-024 Macro CONV_MEM_WRCHK_EN SHALL be the only compile option.
REQ-025 With CONV_MEM_WRCHK_EN defined: output mem_err (1 bit, sticky) SHALL be set by cwr=1 with csel of 000/110/111, by cwr&crd both high in one cycle, or by any master access outside RUN; it is cleared by reset or start.
REQ-026 Without CONV_MEM_WRCHK_EN: mem_err SHALL be absent, and illegal-csel writes are silently dropped.

Verification
REQ-027 Reset, then start, then 16 beats of values 0..15 -> ld_ready falls after beat 16, conv_reset=0 next cycle, image[k]=k.
REQ-028 In RUN, crd=1, csel=000, caddr_rd=5 -> cdata_rd=5 in the same cycle; crd=0 -> cdata_rd=0.
REQ-029 cwr=1, csel=101, caddr_wr=3, cdata_wr=7; later busy falls -> DUMP beat 3 gives out_addr=3, out_data=7.
REQ-030 Hold out_ready=0 for 4 cycles at dp_cnt=2 -> out_valid=1 throughout with the same addr/data; 8 accepted beats -> done=1, conv_reset=1.
REQ-031 Assert reset mid-LOAD at ld_cnt=9 -> IDLE, ld_ready=0; the next start restarts at image[0].
REQ-032 With CONV_MEM_WRCHK_EN, cwr=1 and csel=111 in RUN -> mem_err=1 next cycle and no bank changes; start clears it.
